intr_gateway_arb: RTL

- Downstream consumer of the per-peripheral interrupt generators.
- Takes the vector of level interrupt lines from those generators and runs a per-source gateway state machine for each line.
- Picks the highest-priority pending source and presents one registered interrupt request with its ID to the core.
- Software-facing claim/complete handshake: a source cannot re-interrupt until its handler signals completion.

---
 rtl/intr_gateway_arb.sv | 112 +++++++++++
 1 files changed

// File: rtl/intr_gateway_arb.sv
// Interrupt gateway and arbiter: one IDLE/PENDING/ACTIVE gateway per level
// source, a highest-priority pick over pending sources above threshold, and a
// registered request plus claim/complete handshake towards the core.
module intr_gateway_arb #(
  parameter int unsigned NumSrc = 8,
  parameter int unsigned PrioW  = 2,
  parameter int unsigned IdW    = $clog2(NumSrc + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumSrc-1:0]       intr_src_i,
  input  logic [NumSrc*PrioW-1:0] prio_i,
  input  logic [PrioW-1:0]        threshold_i,
  input  logic                    claim_i,
  input  logic                    complete_i,
  input  logic [IdW-1:0]          complete_id_i,
  output logic                    irq_o,
  output logic [IdW-1:0]          irq_id_o,
  output logic [IdW-1:0]          claim_id_o,
  output logic                    claim_valid_o,
  output logic [NumSrc-1:0]       pending_o
);

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StActive
  } gw_state_e;

  gw_state_e        r_state   [NumSrc];
  gw_state_e        w_state_d [NumSrc];
  logic             r_irq;
  logic [IdW-1:0]   r_irq_id;
  logic [IdW-1:0]   r_claim_id;
  logic             r_claim_valid;
  logic [IdW-1:0]   w_best_id;
  logic [PrioW-1:0] w_best_prio;
  logic             w_claim_ok;
  logic [IdW-1:0]   w_claim_id_d;

  // Pick the best eligible pending source; strict '>' keeps the lowest index on ties.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    for (int k = 0; k < NumSrc; k++) begin
      if (r_state[k] == StPending && prio_i[k*PrioW +: PrioW] > threshold_i &&
          (w_best_id == '0 || prio_i[k*PrioW +: PrioW] > w_best_prio)) begin
        w_best_id   = IdW'(k + 1);
        w_best_prio = prio_i[k*PrioW +: PrioW];
      end
    end
  end

  // Gateway next-state; a claim only hits the source named by the registered ID.
  always_comb begin
    w_claim_ok = 1'b0;
    for (int k = 0; k < NumSrc; k++) begin
      w_state_d[k] = r_state[k];
      unique case (r_state[k])
        StIdle: begin
          if (intr_src_i[k]) w_state_d[k] = StPending;
        end
        StPending: begin
          if (claim_i && r_irq_id == IdW'(k + 1)) begin
            w_state_d[k] = StActive;
            w_claim_ok   = 1'b1;
          end
        end
        StActive: begin
          if (complete_i && complete_id_i == IdW'(k + 1)) w_state_d[k] = StIdle;
        end
        default: w_state_d[k] = StIdle;
      endcase
    end
    w_claim_id_d = w_claim_ok ? r_irq_id : '0;
  end

  // Status view of which gateways hold a pending request.
  always_comb begin
    pending_o = '0;
    for (int k = 0; k < NumSrc; k++) begin
      pending_o[k] = (r_state[k] == StPending);
    end
  end

  // State, request and claim-response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumSrc; k++) begin
        r_state[k] <= StIdle;
      end
      r_irq         <= 1'b0;
      r_irq_id      <= '0;
      r_claim_id    <= '0;
      r_claim_valid <= 1'b0;
    end else begin
      for (int k = 0; k < NumSrc; k++) begin
        r_state[k] <= w_state_d[k];
      end
      r_irq         <= (w_best_id != '0);
      r_irq_id      <= w_best_id;
      r_claim_valid <= claim_i;
      if (claim_i) r_claim_id <= w_claim_id_d;
    end
  end

  assign irq_o         = r_irq;
  assign irq_id_o      = r_irq_id;
  assign claim_id_o    = r_claim_id;
  assign claim_valid_o = r_claim_valid;

endmodule
